combo_code_sender: RTL and testbench

- Initiator side of the combination-lock interface: plays a stored DIGITS-long sequence of 4-bit codes into a lock's code/RST inputs, then watches the lock's status bus for the unlock flag.
- Sits on the user-logic side of the lock, for self-test and automated entry.
- Produces exactly the code/RST stimulus the lock consumes, plus a pass/fail result.

---
 rtl/combo_code_sender.sv | 156 +++++++++++++++
 tb/tb_combo_code_sender.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/combo_code_sender.sv
// Initiator side of the combination-lock interface: pulses the lock's reset,
// plays a latched digit sequence onto code, then waits a bounded time for the unlock flag.
module combo_code_sender #(
  parameter int DIGITS       = 4,
  parameter int RST_CYCLES   = 2,
  parameter int HOLD_CYCLES  = 2,
  parameter int GAP_CYCLES   = 1,
  parameter int CHECK_CYCLES = 4,
  parameter int UNLOCK_BIT   = 4
) (
  input  logic                  CLK,
  input  logic                  masterRST,
  input  logic                  start,
  input  logic                  abort,
  input  logic [4*DIGITS-1:0]   seq_in,
  input  logic [4:0]            lock_out,
  output logic [3:0]            code,
  output logic                  lock_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  unlocked
);

  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int T_A    = (RST_CYCLES > HOLD_CYCLES) ? RST_CYCLES : HOLD_CYCLES;
  localparam int T_B    = (GAP_CYCLES > CHECK_CYCLES) ? GAP_CYCLES : CHECK_CYCLES;
  localparam int T_MAX  = (T_A > T_B) ? T_A : T_B;
  localparam int CNT_W  = ($clog2(T_MAX) > 0) ? $clog2(T_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CHECK_LAST = CNT_W'(CHECK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, RESET, DRIVE, GAP, CHECK, DONE} state_t;

  state_t                   state_reg;
  logic [CNT_W-1:0]         cnt_reg;
  logic [IDX_W-1:0]         idx_reg;
  logic [DIGITS-1:0][3:0]   seq_reg;

  logic [IDX_W-1:0]         next_idx;
  logic                     last_digit;
  logic                     unused_lock_bits;

  assign next_idx         = idx_reg + 1'b1;
  assign last_digit       = (idx_reg == IDX_LAST);
  assign unused_lock_bits = ^lock_out;

  // Every state change also sets the outputs for the cycle it opens, so the
  // state register always names the phase currently visible on the pins.
  always_ff @(posedge CLK) begin
    if (masterRST) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      seq_reg   <= '0;
      code      <= 4'h0;
      lock_rst  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      unlocked  <= 1'b0;
    end else if (abort && state_reg != IDLE) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      code      <= 4'h0;
      lock_rst  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      unlocked  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && !abort) begin
            seq_reg   <= seq_in;
            unlocked  <= 1'b0;
            busy      <= 1'b1;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            state_reg <= LAUNCH;
          end
        end
        LAUNCH: begin
          lock_rst  <= 1'b1;
          state_reg <= RESET;
        end
        RESET: begin
          if (cnt_reg == RST_LAST) begin
            cnt_reg   <= '0;
            idx_reg   <= '0;
            lock_rst  <= 1'b0;
            code      <= seq_reg[0];
            state_reg <= DRIVE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt_reg == HOLD_LAST) begin
            cnt_reg <= '0;
            if (GAP_CYCLES > 0) begin
              code      <= 4'h0;
              state_reg <= GAP;
            end else if (last_digit) begin
              code      <= 4'h0;
              state_reg <= CHECK;
            end else begin
              idx_reg   <= next_idx;
              code      <= seq_reg[next_idx];
              state_reg <= DRIVE;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        GAP: begin
          if (cnt_reg == GAP_LAST) begin
            cnt_reg <= '0;
            if (last_digit) begin
              state_reg <= CHECK;
            end else begin
              idx_reg   <= next_idx;
              code      <= seq_reg[next_idx];
              state_reg <= DRIVE;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        CHECK: begin
          // Each edge here samples the flag as it stood during a CHECK cycle.
          if (lock_out[UNLOCK_BIT]) begin
            unlocked  <= 1'b1;
            done      <= 1'b1;
            state_reg <= DONE;
          end else if (cnt_reg == CHECK_LAST) begin
            done      <= 1'b1;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          cnt_reg   <= '0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_combo_code_sender.sv
// Randomized self-checking bench for combo_code_sender: a timeline model of each
// attempt predicts every output per cycle; a second instance covers non-default parameters.
module tb_combo_code_sender;

  localparam int RST   = 2;
  localparam int DIG   = 4;
  localparam int HOLD  = 2;
  localparam int GAP   = 1;
  localparam int CHECK = 4;

  logic        CLK = 1'b0;
  logic        masterRST;
  logic        start, abort;
  logic [15:0] seq_in;
  logic [4:0]  lock_out;
  logic [3:0]  code;
  logic        lock_rst, busy, done, unlocked;

  logic        start_p;
  logic [7:0]  seq_p;
  logic [3:0]  code_p;
  logic        lock_rst_p, busy_p, done_p, unlocked_p;

  int n_checks = 0;
  int n_pass   = 0;

  int          mode_sel = 0;
  logic        lock_u   = 1'b0;
  logic [3:0]  lock_low = 4'h0;
  logic [15:0] hist     = 16'h0;
  logic [3:0]  prev_code = 4'h0;

  always #5 CLK = ~CLK;

  combo_code_sender dut (
    .CLK(CLK), .masterRST(masterRST), .start(start), .abort(abort),
    .seq_in(seq_in), .lock_out(lock_out), .code(code), .lock_rst(lock_rst),
    .busy(busy), .done(done), .unlocked(unlocked)
  );

  combo_code_sender #(.DIGITS(2), .HOLD_CYCLES(1), .GAP_CYCLES(0)) dut_p (
    .CLK(CLK), .masterRST(masterRST), .start(start_p), .abort(1'b0),
    .seq_in(seq_p), .lock_out(5'b0), .code(code_p), .lock_rst(lock_rst_p),
    .busy(busy_p), .done(done_p), .unlocked(unlocked_p)
  );

  // Bench lock: remembers each newly presented nonzero digit, opens on 9,5,2,7.
  always @(posedge CLK) begin
    if (lock_rst) begin
      hist      <= 16'h0;
      prev_code <= 4'h0;
    end else begin
      prev_code <= code;
      if (code != 4'h0 && code != prev_code) hist <= {hist[11:0], code};
    end
  end

  assign lock_out = {((mode_sel == 1) && (hist == 16'h9527)) || lock_u, lock_low};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Expected {code, lock_rst, busy, done, unlocked} in cycle c of an attempt ending at D.
  function automatic logic [7:0] exp_vec(input int c, input int dg, input int hd, input int gp,
                                         input logic [15:0] seq, input int D, input bit unl);
    logic [3:0] cd;
    logic rs, by, dn, ul;
    int off;
    cd = 4'h0; rs = 1'b0; by = 1'b0; dn = 1'b0; ul = 1'b0;
    if (c <= D) begin
      by  = 1'b1;
      dn  = (c == D);
      ul  = (c == D) ? unl : 1'b0;
      rs  = (c >= 1 && c <= RST);
      off = c - 1 - RST;
      if (off >= 0 && off < dg * (hd + gp) && (off % (hd + gp)) < hd)
        cd = seq[4 * (off / (hd + gp)) +: 4];
    end else begin
      ul = unl;
    end
    return {cd, rs, by, dn, ul};
  endfunction

  // mode 0: lock silent; 1: bench lock; 2: flag high only in cycle u.
  // a: cycle during which abort is held (-1 none); s2: cycle of an extra start (-1 none).
  task automatic run_attempt(input int att, input logic [15:0] seq, input int mode,
                             input int u, input int a, input int s2);
    int cs, D, last;
    bit unl, aborted;
    logic [7:0] ev;
    cs = 1 + RST + DIG * (HOLD + GAP);
    if (mode == 1) begin
      unl = (seq == 16'h7259);
      D   = unl ? cs + 1 : cs + CHECK;
    end else if (mode == 2 && u >= cs && u < cs + CHECK) begin
      unl = 1'b1;
      D   = u + 1;
    end else begin
      unl = 1'b0;
      D   = cs + CHECK;
    end
    aborted = (a >= 0 && a <= D);
    last = aborted ? a + 2 : D + 2;
    mode_sel = mode;
    seq_in = seq;
    start  = 1'b1;
    @(posedge CLK); #1;
    start  = 1'b0;
    seq_in = 16'($urandom);
    for (int c = 0; c <= last; c++) begin
      ev = (aborted && c > a) ? 8'h00 : exp_vec(c, DIG, HOLD, GAP, seq, D, unl);
      check($sformatf("att%0d c%0d", att, c), {24'h0, code, lock_rst, busy, done, unlocked}, {24'h0, ev});
      lock_u   = (mode == 2 && c == u);
      lock_low = 4'($urandom);
      abort    = (c == a);
      start    = (c == s2);
      @(posedge CLK); #1;
    end
    lock_u = 1'b0; abort = 1'b0; start = 1'b0;
    $display("attempt %0d seq=%h mode=%0d u=%0d abort=%0d exp_unlocked=%0d exp_done_cycle=%0d",
             att, seq, mode, u, a, aborted ? 0 : unl, aborted ? -1 : D);
  endtask

  initial begin
    masterRST = 1'b1; start = 1'b0; abort = 1'b0; seq_in = 16'h0;
    start_p = 1'b0; seq_p = 8'h0;
    repeat (3) @(posedge CLK);
    #1 masterRST = 1'b0;
    check("reset", {24'h0, code, lock_rst, busy, done, unlocked}, 32'h0);
    check("reset_p", {24'h0, code_p, lock_rst_p, busy_p, done_p, unlocked_p}, 32'h0);

    run_attempt(1, 16'h4321, 0, -1, -1, -1);
    run_attempt(2, 16'h7259, 1, -1, -1, -1);
    run_attempt(3, 16'h1111, 0, -1, -1, -1);
    run_attempt(4, 16'h8888, 2, 18, -1, -1);
    run_attempt(5, 16'h8888, 2, 19, -1, -1);
    run_attempt(6, 16'h4321, 0, -1, 7, -1);
    run_attempt(7, 16'h4321, 0, -1, -1, 5);
    run_attempt(8, 16'h7259, 1, -1, 16, -1);

    // start and abort together while idle: nothing starts
    start = 1'b1; abort = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("start_abort_idle c%0d", c), {31'h0, busy}, 32'h0);
      @(posedge CLK); #1;
    end
    $display("attempt 9 start+abort in idle, exp_busy=0");

    for (int i = 0; i < 6; i++) begin
      int u, a;
      u = int'($urandom_range(12, 21));
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
      run_attempt(10 + i, 16'($urandom), 2, u, a, -1);
    end

    // Reduced-parameter instance, reset in the middle of CHECK
    seq_p   = 8'hA5;
    start_p = 1'b1;
    @(posedge CLK); #1;
    start_p = 1'b0;
    seq_p   = 8'h00;
    for (int c = 0; c <= 7; c++) begin
      if (c <= 6)
        check($sformatf("param c%0d", c), {24'h0, code_p, lock_rst_p, busy_p, done_p, unlocked_p},
              {24'h0, exp_vec(c, 2, 1, 0, 16'h00A5, 5 + CHECK, 1'b0)});
      else
        check("param after reset", {24'h0, code_p, lock_rst_p, busy_p, done_p, unlocked_p}, 32'h0);
      masterRST = (c == 6);
      @(posedge CLK); #1;
    end
    masterRST = 1'b0;
    check("main after reset", {24'h0, code, lock_rst, busy, done, unlocked}, 32'h0);
    $display("attempt 16 param seq=a5 reset in CHECK");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
